light_dance_ctrl: RTL and testbench

Sequencer and two-way arbiter for the 8-bit light-dance shift register. Two requesters each submit a seed pattern, a step count and a serial-input mode. The block grants one requester round-robin, loads the seed into the register, and clocks it for the requested number of steps. It then captures the final pattern and acknowledges the requester. It sits beside the register instance and owns its `load`, `pdata` and `din` inputs, observing its `qdata`.

---
 rtl/light_dance_ctrl_if.sv | 36 +++
 rtl/light_dance_ctrl.sv | 134 +++++++++++++
 tb/tb_light_dance_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/light_dance_ctrl_if.sv
// light_dance_ctrl_if: request/acknowledge bundle between the two requesters and
// the light-dance sequencer.
//   req[1:0]          per-requester request, held until the matching ack pulse
//   pattern0/1        8-bit seed pattern per requester
//   steps0/1          STEP_W-bit shift-step count per requester
//   mode0/1           2-bit serial-input mode per requester
//   ack[1:0]          one-cycle completion pulse per requester
//   busy              sequencer is not idle
//   gnt_id            current or most recent grantee
//   result            final register value of the last completed job
// Modports: master = requester side, slave = sequencer side.
interface light_dance_ctrl_if #(
   parameter int unsigned STEP_W = 8
);
   logic [1:0]        req;
   logic [7:0]        pattern0;
   logic [7:0]        pattern1;
   logic [STEP_W-1:0] steps0;
   logic [STEP_W-1:0] steps1;
   logic [1:0]        mode0;
   logic [1:0]        mode1;
   logic [1:0]        ack;
   logic              busy;
   logic              gnt_id;
   logic [7:0]        result;

   modport master (
      output req, pattern0, pattern1, steps0, steps1, mode0, mode1,
      input  ack, busy, gnt_id, result
   );

   modport slave (
      input  req, pattern0, pattern1, steps0, steps1, mode0, mode1,
      output ack, busy, gnt_id, result
   );
endinterface

// File: rtl/light_dance_ctrl.sv
// light_dance_ctrl: round-robin two-way arbiter and sequencer for the 8-bit
// light-dance shift register. A granted job loads its seed, shifts the register
// for the requested number of steps with the selected serial input, captures the
// final value into result and pulses ack for the requester.
// Ports:
//   clk_i        clock, rising edge
//   arst_i       synchronous active-high reset
//   bus_if       requester bundle (light_dance_ctrl_if.slave)
//   ld_load_o    register load enable
//   ld_pdata_o   register parallel load data
//   ld_din_o     register serial input
//   ld_qdata_i   register current value
// Optional feature: define LD_LOCKUP_STOP_EN to end a mode-00 job early as soon
// as the register reads all-zero during RUN (all-zero is a fixed point for din=0).
module light_dance_ctrl #(
   parameter int unsigned STEP_W = 8
) (
   input  logic               clk_i,
   input  logic               arst_i,
   light_dance_ctrl_if.slave  bus_if,
   output logic               ld_load_o,
   output logic [7:0]         ld_pdata_o,
   output logic               ld_din_o,
   input  logic [7:0]         ld_qdata_i
);

   typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

   state_e            state_q,   state_d;
   logic [7:0]        pattern_q, pattern_d;
   logic [STEP_W-1:0] steps_q,   steps_d;
   logic [1:0]        mode_q,    mode_d;
   logic              gnt_q,     gnt_d;
   logic              last_q,    last_d;
   logic              phase_q,   phase_d;
   logic [7:0]        result_q,  result_d;

   logic              grant_sel;
   logic [1:0]        ack;

   // With both requesting, the one not granted last wins; otherwise the sole requester.
   always_comb begin
      grant_sel = (bus_if.req == 2'b11) ? ~last_q : bus_if.req[1];
   end

   always_comb begin
      state_d    = state_q;
      pattern_d  = pattern_q;
      steps_d    = steps_q;
      mode_d     = mode_q;
      gnt_d      = gnt_q;
      last_d     = last_q;
      phase_d    = phase_q;
      result_d   = result_q;
      ack        = 2'b00;
      ld_load_o  = 1'b0;
      ld_pdata_o = 8'h00;
      ld_din_o   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (|bus_if.req) begin
               gnt_d     = grant_sel;
               last_d    = grant_sel;
               pattern_d = grant_sel ? bus_if.pattern1 : bus_if.pattern0;
               steps_d   = grant_sel ? bus_if.steps1   : bus_if.steps0;
               mode_d    = grant_sel ? bus_if.mode1    : bus_if.mode0;
               phase_d   = 1'b0;
               state_d   = StLoad;
            end
         end
         StLoad: begin
            ld_load_o  = 1'b1;
            ld_pdata_o = pattern_q;
            state_d    = (steps_q == '0) ? StDone : StRun;
         end
         StRun: begin
            // phase_q is 0 on the first RUN cycle; mode 10 starts at 1, mode 11 at 0.
            unique case (mode_q)
               2'b00:   ld_din_o = 1'b0;
               2'b01:   ld_din_o = 1'b1;
               2'b10:   ld_din_o = ~phase_q;
               default: ld_din_o = phase_q;
            endcase
            phase_d = ~phase_q;
            steps_d = steps_q - STEP_W'(1);
            if (steps_q == STEP_W'(1)) begin
               state_d = StDone;
            end
`ifdef LD_LOCKUP_STOP_EN
            if ((mode_q == 2'b00) && (ld_qdata_i == 8'h00)) begin
               state_d = StDone;
            end
`endif
         end
         StDone: begin
            result_d = ld_qdata_i;
            ack      = gnt_q ? 2'b10 : 2'b01;
            state_d  = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (arst_i) begin
         state_q   <= StIdle;
         pattern_q <= 8'h00;
         steps_q   <= '0;
         mode_q    <= 2'b00;
         gnt_q     <= 1'b0;
         last_q    <= 1'b1;
         phase_q   <= 1'b0;
         result_q  <= 8'h00;
      end else begin
         state_q   <= state_d;
         pattern_q <= pattern_d;
         steps_q   <= steps_d;
         mode_q    <= mode_d;
         gnt_q     <= gnt_d;
         last_q    <= last_d;
         phase_q   <= phase_d;
         result_q  <= result_d;
      end
   end

   assign bus_if.ack    = ack;
   assign bus_if.busy   = (state_q != StIdle);
   assign bus_if.gnt_id = gnt_q;
   assign bus_if.result = result_q;

endmodule

// File: tb/tb_light_dance_ctrl.sv
// tb_light_dance_ctrl: randomized self-checking bench for light_dance_ctrl.
// Contains a behavioural stand-in for the light-dance register and a job-level
// reference model (final pattern, run length, serial-input sequence, grant order).
module tb_light_dance_ctrl;
   localparam int unsigned STEP_W = 8;

   logic       clk;
   logic       arst;
   logic       ld_load;
   logic [7:0] ld_pdata;
   logic       ld_din;
   logic [7:0] reg_q = 8'h00;

   int n_checks = 0;
   int n_pass   = 0;
   logic last_gnt = 1'b1;

   light_dance_ctrl_if #(.STEP_W(STEP_W)) bif ();

   light_dance_ctrl #(.STEP_W(STEP_W)) dut (
      .clk_i      (clk),
      .arst_i     (arst),
      .bus_if     (bif),
      .ld_load_o  (ld_load),
      .ld_pdata_o (ld_pdata),
      .ld_din_o   (ld_din),
      .ld_qdata_i (reg_q)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Light-dance register: right shift with din into MSB, Galois feedback mask 0xB3.
   function automatic logic [7:0] reg_next(input logic [7:0] q, input logic din);
      return {din, q[7:1]} ^ (q[0] ? 8'hB3 : 8'h00);
   endfunction

   always_ff @(posedge clk) begin
      reg_q <= ld_load ? ld_pdata : reg_next(reg_q, ld_din);
   end

   function automatic logic exp_din(input logic [1:0] md, input int k);
      case (md)
         2'b00:   return 1'b0;
         2'b01:   return 1'b1;
         2'b10:   return (k % 2) == 0;
         default: return (k % 2) == 1;
      endcase
   endfunction

   // Job model: final register value and number of shifts actually performed.
   task automatic model_job(input logic [7:0] pat, input int st, input logic [1:0] md,
                            output logic [7:0] res, output int len);
      logic [7:0] q;
      logic       stop;
      q   = pat;
      len = 0;
      for (int k = 0; k < st; k++) begin
`ifdef LD_LOCKUP_STOP_EN
         stop = (md == 2'b00) && (q == 8'h00);
`else
         stop = 1'b0;
`endif
         q = reg_next(q, exp_din(md, k));
         len++;
         if (stop) break;
      end
      res = q;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic set_fields(input int id, input logic [7:0] pat, input int st,
                             input logic [1:0] md);
      if (id == 0) begin
         bif.pattern0 = pat; bif.steps0 = STEP_W'(st); bif.mode0 = md;
      end else begin
         bif.pattern1 = pat; bif.steps1 = STEP_W'(st); bif.mode1 = md;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      arst    = 1'b1;
      bif.req = 2'b00;
      repeat (2) @(negedge clk);
      arst     = 1'b0;
      last_gnt = 1'b1;
   endtask

   task automatic run_single(input int id, input logic [7:0] pat, input int st,
                             input logic [1:0] md);
      logic [7:0] exp_r;
      int         len;
      int         n;
      bit         got;
      model_job(pat, st, md, exp_r, len);
      @(negedge clk);
      set_fields(id, pat, st, md);
      bif.req[id] = 1'b1;
      n   = 0;
      got = 0;
      while (!got && n < 600) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            check("load", ld_load, 1);
            check("pdata", ld_pdata, pat);
            check("gnt_id", bif.gnt_id, id);
            check("busy", bif.busy, 1);
         end else if (n < 2 + len) begin
            check("din", ld_din, exp_din(md, n - 2));
         end
         if (bif.ack != 2'b00) begin
            got = 1;
            check("ack_bits", bif.ack, (id == 1) ? 2 : 1);
            check("ack_latency", n, 2 + len);
            bif.req[id] = 1'b0;
         end
      end
      if (!got) check("ack_timeout", 0, 1);
      @(negedge clk);
      check("result", bif.result, exp_r);
      check("idle_busy", bif.busy, 0);
      check("idle_ack", bif.ack, 0);
      last_gnt = id[0];
   endtask

   task automatic run_dual(input logic [7:0] p0, input int s0, input logic [1:0] m0,
                           input logic [7:0] p1, input int s1, input logic [1:0] m1);
      logic [7:0] r0, r1, rf, rs, pexp;
      int         l0, l1, lf, ls;
      int         n, a_first, a_second;
      logic       first;
      bit         pend;
      model_job(p0, s0, m0, r0, l0);
      model_job(p1, s1, m1, r1, l1);
      first = ~last_gnt;
      rf = first ? r1 : r0;  lf = first ? l1 : l0;
      rs = first ? r0 : r1;  ls = first ? l0 : l1;
      @(negedge clk);
      set_fields(0, p0, s0, m0);
      set_fields(1, p1, s1, m1);
      bif.req  = 2'b11;
      n        = 0;
      a_first  = -1;
      a_second = -1;
      pend     = 0;
      pexp     = 8'h00;
      while (a_second < 0 && n < 1200) begin
         @(negedge clk);
         n++;
         if (pend) begin
            check("dual_result", bif.result, pexp);
            pend = 0;
         end
         if (n == 1) check("dual_first_gnt", bif.gnt_id, first);
         if (bif.ack != 2'b00) begin
            if (a_first < 0) begin
               a_first = n;
               check("dual_ack_first", bif.ack, first ? 2 : 1);
               bif.req[first] = 1'b0;
               pexp = rf;
            end else begin
               a_second = n;
               check("dual_ack_second", bif.ack, first ? 1 : 2);
               bif.req[~first] = 1'b0;
               pexp = rs;
            end
            pend = 1;
         end
      end
      if (a_second < 0) begin
         check("dual_timeout", 0, 1);
         bif.req = 2'b00;
      end else begin
         @(negedge clk);
         check("dual_result", bif.result, pexp);
         check("dual_lat_first", a_first, 2 + lf);
         check("dual_ack_gap", a_second - a_first, 3 + ls);
      end
      last_gnt = ~first;
   endtask

   initial begin
      logic [7:0] pat;
      arst     = 1'b1;
      bif.req  = 2'b00;
      set_fields(0, 8'h00, 0, 2'b00);
      set_fields(1, 8'h00, 0, 2'b00);
      repeat (2) @(negedge clk);
      check("rst_busy", bif.busy, 0);
      check("rst_ack", bif.ack, 0);
      check("rst_gnt", bif.gnt_id, 0);
      check("rst_result", bif.result, 8'h00);
      check("rst_load", ld_load, 0);
      check("rst_pdata", ld_pdata, 8'h00);
      check("rst_din", ld_din, 0);
      arst = 1'b0;

      // Both requesting straight out of reset: requester 0 first, acks 5 apart.
      run_dual(8'h3C, 2, 2'b01, 8'hC3, 2, 2'b10);

      run_single(0, 8'h01, 1, 2'b00);
      check("b3_result", bif.result, 8'hB3);
      run_single(1, 8'h5A, 0, 2'b01);
      check("zero_steps_result", bif.result, 8'h5A);
      run_single(0, 8'h96, 4, 2'b10);
      run_single(1, 8'h00, 10, 2'b00);
      check("zero_fixed_point", bif.result, 8'h00);

      // Reset in the second RUN cycle of a 5-step job.
      @(negedge clk);
      set_fields(0, 8'hA5, 5, 2'b01);
      bif.req = 2'b01;
      repeat (3) @(negedge clk);
      check("pre_abort_busy", bif.busy, 1);
      arst    = 1'b1;
      bif.req = 2'b00;
      @(negedge clk);
      check("abort_busy", bif.busy, 0);
      check("abort_ack", bif.ack, 0);
      check("abort_result", bif.result, 8'h00);
      check("abort_gnt", bif.gnt_id, 0);
      check("abort_load", ld_load, 0);
      check("abort_din", ld_din, 0);
      arst     = 1'b0;
      last_gnt = 1'b1;
      run_dual(8'h11, 3, 2'b11, 8'h22, 1, 2'b01);

      for (int i = 0; i < 40; i++) begin
         int st0, st1;
         st0 = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
         st1 = $urandom_range(0, 15);
         pat = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
         if ($urandom_range(0, 3) == 0)
            run_dual(pat, st0, 2'($urandom), 8'($urandom), st1, 2'($urandom));
         else
            run_single($urandom_range(0, 1), pat, st0, 2'($urandom));
      end

      do_reset();
      run_single(0, 8'h80, 3, 2'b11);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
